// File: rtl/and_priority_encoder.sv
// and_priority_encoder
// ANDs two occupancy vectors and walks the set bits of the result one index
// per active cycle, lowest index first, flagging the final index so the
// upstream sequencer knows when to present the next vector pair.
`timescale 1ns/1ps
module and_priority_encoder #(
  parameter int SIZE = 128,
  localparam int AW = $clog2(SIZE)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [SIZE-1:0] in1_i,
  input  logic [SIZE-1:0] in2_i,
  output logic            valid_o,
  output logic [AW-1:0]   match_addr_o,
  output logic            pri_enc_end_o
);

  localparam logic ST_INPUT_CHANGE = 1'b0;
  localparam logic ST_FLY          = 1'b1;

  logic            state_r;
  logic [SIZE-1:0] pend_r;
  logic [SIZE-1:0] and_w;
  logic [SIZE-1:0] enc_in;
  logic [AW:0]     enc;
  logic [SIZE-1:0] rem;
  logic            pri_end;

  // Lowest-set-bit encoder built as a balanced pairwise reduction tree.
  // Each level halves the node count; a node keeps the left child's index
  // whenever the left child has any bit set. All-zero input yields SIZE.
  function automatic logic [AW:0] pri_enc(input logic [SIZE-1:0] x);
    logic [SIZE-1:0] v;
    logic [AW-1:0]   ix [SIZE];
    v = x;
    for (int i = 0; i < SIZE; i++) begin
      ix[i] = AW'(i);
    end
    for (int l = 1; l <= AW; l++) begin
      for (int n = 0; n < (SIZE >> l); n++) begin
        ix[n] = v[2*n] ? ix[2*n] : ix[2*n+1];
        v[n]  = v[2*n] | v[2*n+1];
      end
    end
    return v[0] ? {1'b0, ix[0]} : (AW+1)'(SIZE);
  endfunction

  assign and_w = in1_i & in2_i;

  // Encoder source: fresh AND result on a new pair, remaining bits while in flight.
  always_comb begin
    enc_in = '1;
    if (valid_i) begin
      enc_in = (state_r == ST_FLY) ? pend_r : and_w;
    end
  end

  assign enc     = pri_enc(enc_in);
  assign rem     = enc_in & ~({{(SIZE-1){1'b0}}, 1'b1} << enc[AW-1:0]);
  assign pri_end = valid_i & ~(|rem);

  assign match_addr_o  = rst_i ? enc[AW-1:0] : '0;
  assign valid_o       = rst_i & valid_i & ~enc[AW];
  assign pri_enc_end_o = rst_i & pri_end;

  // Walk the pending bits; hold everything while valid_i is low.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_INPUT_CHANGE;
      pend_r  <= '0;
    end else if (valid_i) begin
      case (state_r)
        ST_INPUT_CHANGE: begin
          pend_r  <= rem;
          state_r <= pri_end ? ST_INPUT_CHANGE : ST_FLY;
        end
        default: begin
          if (!pri_end) begin
            pend_r <= rem;
          end else begin
            state_r <= ST_INPUT_CHANGE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and_priority_encoder.sv
// Self-checking bench for and_priority_encoder: one SIZE=8 instance for the
// functional scenarios and one SIZE=128 instance for the full-width sweep.
`timescale 1ns/1ps
module tb_and_priority_encoder;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         rst_i;
  logic         valid8;
  logic [7:0]   a8, b8;
  logic         v8_o, end8_o;
  logic [2:0]   addr8_o;
  logic         valid128;
  logic [127:0] a128, b128;
  logic         v128_o, end128_o;
  logic [6:0]   addr128_o;

  and_priority_encoder #(.SIZE(8)) dut8 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid8),
    .in1_i(a8), .in2_i(b8),
    .valid_o(v8_o), .match_addr_o(addr8_o), .pri_enc_end_o(end8_o)
  );

  and_priority_encoder #(.SIZE(128)) dut128 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid128),
    .in1_i(a128), .in2_i(b128),
    .valid_o(v128_o), .match_addr_o(addr128_o), .pri_enc_end_o(end128_o)
  );

  typedef struct packed {
    logic       v;
    logic [6:0] a;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  // Expected index stream for an AND result: every set bit ascending, end on the highest.
  function automatic void push_seq(input logic [127:0] andv, input int size);
    int last;
    exp_t x;
    last = -1;
    for (int i = 0; i < size; i++) begin
      if (andv[i]) last = i;
    end
    if (last < 0) begin
      x = '{v: 1'b0, a: 7'd0, e: 1'b1};
      sb.push_back(x);
    end else begin
      for (int i = 0; i < size; i++) begin
        if (andv[i]) begin
          x = '{v: 1'b1, a: 7'(i), e: (i == last)};
          sb.push_back(x);
        end
      end
    end
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    valid8 = 1'b1;  a8 = 8'hFF;  b8 = 8'hFF;
    valid128 = 1'b1; a128 = '1;  b128 = '1;
    #3;
    checks++;
    if ({v8_o, addr8_o, end8_o} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL reset8: got v=%b a=%0d e=%b, want all 0", v8_o, addr8_o, end8_o);
    end
    checks++;
    if ({v128_o, addr128_o, end128_o} !== 9'b0) begin
      fails++;
      $display("[TB] FAIL reset128: got v=%b a=%0d e=%b, want all 0", v128_o, addr128_o, end128_o);
    end
    next_cycle();
    rst_i = 1'b1;
    valid8 = 1'b0;
    valid128 = 1'b0;
    #3;
    checks++;
    if ({v8_o, end8_o} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL idle8: got v=%b e=%b, want 0 0", v8_o, end8_o);
    end
  endtask

  task automatic test_sequence();
    exp_t e;
    push_seq(128'hB2, 8);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      valid8 = 1'b1; a8 = 8'hB6; b8 = 8'hF3;
      #3;
      e = sb.pop_front();
      checks++;
      if ({v8_o, addr8_o, end8_o} !== {e.v, e.a[2:0], e.e}) begin
        fails++;
        $display("[TB] FAIL seq c%0d: got v=%b a=%0d e=%b, want v=%b a=%0d e=%b",
                 c, v8_o, addr8_o, end8_o, e.v, e.a[2:0], e.e);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] ta [4] = '{8'h08, 8'hF0, 8'h81, 8'h81};
    logic [7:0] tb [4] = '{8'hFF, 8'h0F, 8'hC3, 8'hC3};
    push_seq(128'h08, 8);
    push_seq(128'h00, 8);
    push_seq(128'h81, 8);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      valid8 = 1'b1; a8 = ta[c]; b8 = tb[c];
      #3;
      e = sb.pop_front();
      checks++;
      if ({v8_o, addr8_o, end8_o} !== {e.v, e.a[2:0], e.e}) begin
        fails++;
        $display("[TB] FAIL b2b c%0d: got v=%b a=%0d e=%b, want v=%b a=%0d e=%b",
                 c, v8_o, addr8_o, end8_o, e.v, e.a[2:0], e.e);
      end
    end
  endtask

  task automatic test_pause();
    exp_t e;
    logic       tv [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] ta [6] = '{8'hB6, 8'hB6, 8'hFF, 8'h01, 8'hFF, 8'h01};
    logic [7:0] tb [6] = '{8'hF3, 8'hF3, 8'hFF, 8'h01, 8'hFF, 8'h01};
    sb.push_back('{v: 1'b1, a: 7'd1, e: 1'b0});
    sb.push_back('{v: 1'b1, a: 7'd4, e: 1'b0});
    sb.push_back('{v: 1'b0, a: 7'd0, e: 1'b0});
    sb.push_back('{v: 1'b0, a: 7'd0, e: 1'b0});
    sb.push_back('{v: 1'b1, a: 7'd5, e: 1'b0});
    sb.push_back('{v: 1'b1, a: 7'd7, e: 1'b1});
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      valid8 = tv[c]; a8 = ta[c]; b8 = tb[c];
      #3;
      e = sb.pop_front();
      checks++;
      if ({v8_o, addr8_o, end8_o} !== {e.v, e.a[2:0], e.e}) begin
        fails++;
        $display("[TB] FAIL pause c%0d: got v=%b a=%0d e=%b, want v=%b a=%0d e=%b",
                 c, v8_o, addr8_o, end8_o, e.v, e.a[2:0], e.e);
      end
    end
  endtask

  task automatic test_reset_fly();
    exp_t e;
    push_seq(128'hB2, 8);
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      valid8 = 1'b1; a8 = 8'hB6; b8 = 8'hF3;
      #3;
      e = sb.pop_front();
      checks++;
      if ({v8_o, addr8_o, end8_o} !== {e.v, e.a[2:0], e.e}) begin
        fails++;
        $display("[TB] FAIL prerst c%0d: got v=%b a=%0d e=%b, want v=%b a=%0d e=%b",
                 c, v8_o, addr8_o, end8_o, e.v, e.a[2:0], e.e);
      end
    end
    sb.delete();
    next_cycle();
    rst_i = 1'b0;
    #1;
    checks++;
    if ({v8_o, addr8_o, end8_o} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL rstfly: got v=%b a=%0d e=%b, want all 0", v8_o, addr8_o, end8_o);
    end
    push_seq(128'hB2, 8);
    next_cycle();
    rst_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) next_cycle();
      #3;
      e = sb.pop_front();
      checks++;
      if ({v8_o, addr8_o, end8_o} !== {e.v, e.a[2:0], e.e}) begin
        fails++;
        $display("[TB] FAIL postrst c%0d: got v=%b a=%0d e=%b, want v=%b a=%0d e=%b",
                 c, v8_o, addr8_o, end8_o, e.v, e.a[2:0], e.e);
      end
    end
    next_cycle();
    valid8 = 1'b0;
  endtask

  task automatic test_full128();
    exp_t e;
    push_seq('1, 128);
    sb.push_back('{v: 1'b1, a: 7'd0, e: 1'b0});
    for (int c = 0; c < 129; c++) begin
      next_cycle();
      valid128 = 1'b1; a128 = '1; b128 = '1;
      #3;
      e = sb.pop_front();
      checks++;
      if ({v128_o, addr128_o, end128_o} !== {e.v, e.a, e.e}) begin
        fails++;
        $display("[TB] FAIL full128 c%0d: got v=%b a=%0d e=%b, want v=%b a=%0d e=%b",
                 c, v128_o, addr128_o, end128_o, e.v, e.a, e.e);
      end
    end
    next_cycle();
    valid128 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_back_to_back();
    test_pause();
    test_reset_fly();
    test_full128();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard: got %0d leftover entries, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
